// File: rtl/alarm_cnt_bank.sv
// Purpose : NumCh-channel saturating up/down event counters with sticky threshold alarms.
// Latency : cnt_o updates one edge after a request; alarm_o follows cnt_o by one further edge.
// Backpres: none. Requests are level samples and a request held high acts once per cycle.
//
// Ports   : clk_i, rst_i (sync, active-high); incr_en_i/decr_en_i/alarm_clr_i [NumCh];
//           step_i/cnt_o [NumCh*Width], channel k at [k*Width +: Width]; thresh_i [Width]
//           (0 disables alarms); alarm_o [NumCh]; alarm_any_o = OR of alarm_o.
// Option  : define ALARM_CNT_BANK_LEAK_EN to add a periodic leak toward zero every LeakPeriod
//           cycles. Without it LeakPeriod is only range-checked.
module alarm_cnt_bank #(
  parameter int unsigned      NumCh      = 4,
  parameter int unsigned      Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0,
  parameter int unsigned      LeakPeriod = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCh-1:0]       incr_en_i,
  input  logic [NumCh-1:0]       decr_en_i,
  input  logic [NumCh*Width-1:0] step_i,
  input  logic [Width-1:0]       thresh_i,
  input  logic [NumCh-1:0]       alarm_clr_i,
  output logic [NumCh*Width-1:0] cnt_o,
  output logic [NumCh-1:0]       alarm_o,
  output logic                   alarm_any_o
);

  if (NumCh < 1) begin : g_bad_numch
    $error("alarm_cnt_bank: NumCh must be >= 1");
  end
  if (Width < 2) begin : g_bad_width
    $error("alarm_cnt_bank: Width must be >= 2");
  end
  if (LeakPeriod < 2) begin : g_bad_leak
    $error("alarm_cnt_bank: LeakPeriod must be >= 2");
  end

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ALARM  = 1'b1
  } alarm_st_e;

  logic [NumCh-1:0][Width-1:0] cnt_q, cnt_d;
  logic [NumCh-1:0]            cnt_en;
  logic [NumCh-1:0]            thr_hit;
  alarm_st_e                   alarm_st_q [NumCh];
  logic                        leak_pulse;

`ifdef ALARM_CNT_BANK_LEAK_EN
  localparam int unsigned PreW = $clog2(LeakPeriod);

  logic [PreW-1:0] presc_q, presc_d;

  // Free-running prescaler; the pulse cycle is also the wrap cycle.
  assign leak_pulse = (presc_q == PreW'(LeakPeriod - 1));

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (leak_pulse) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign leak_pulse = 1'b0;
`endif

  for (genvar k = 0; k < NumCh; k++) begin : g_ch
    logic [Width-1:0] cnt, step, nxt;
    logic [Width:0]   sum, diff;
    logic             up, dn;

    assign cnt  = cnt_q[k];
    assign step = step_i[k*Width +: Width];
    assign up   = incr_en_i[k] & ~decr_en_i[k];
    assign dn   = decr_en_i[k] & ~incr_en_i[k];
    // One extra bit: carry-out means overflow, borrow means underflow.
    assign sum  = {1'b0, cnt} + {1'b0, step};
    assign diff = {1'b0, cnt} - {1'b0, step};

    always_comb begin
      nxt = cnt;
      if (up) begin
        nxt = sum[Width] ? {Width{1'b1}} : sum[Width-1:0];
      end else if (dn) begin
        nxt = diff[Width] ? {Width{1'b0}} : diff[Width-1:0];
      end else if (leak_pulse && !incr_en_i[k] && !decr_en_i[k] && (cnt != '0)) begin
        // A channel with any request this cycle skips the leak entirely.
        nxt = cnt - 1'b1;
      end
    end

    assign cnt_d[k]   = nxt;
    // Holding at a bound or a zero step leaves the register disabled.
    assign cnt_en[k]  = (nxt != cnt);
    assign thr_hit[k] = (thresh_i != '0) && (cnt >= thresh_i);
    assign alarm_o[k] = (alarm_st_q[k] == ST_ALARM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {NumCh{ResetValue}};
    end else begin
      for (int k = 0; k < NumCh; k++) begin
        if (cnt_en[k]) begin
          cnt_q[k] <= cnt_d[k];
        end
      end
    end
  end

  // Alarm FSM per channel, evaluated on the registered count. Set wins over clear,
  // and a threshold change only alters these conditions, never the state directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumCh; k++) begin
        alarm_st_q[k] <= ST_NORMAL;
      end
    end else begin
      for (int k = 0; k < NumCh; k++) begin
        case (alarm_st_q[k])
          ST_NORMAL: if (thr_hit[k]) alarm_st_q[k] <= ST_ALARM;
          ST_ALARM:  if (alarm_clr_i[k] && !thr_hit[k]) alarm_st_q[k] <= ST_NORMAL;
          default:   alarm_st_q[k] <= ST_NORMAL;
        endcase
      end
    end
  end

  assign cnt_o       = cnt_q;
  assign alarm_any_o = |alarm_o;

endmodule

// File: tb/tb_alarm_cnt_bank.sv
// Purpose : directed check of alarm_cnt_bank (NumCh=4, Width=8, ResetValue=5, LeakPeriod=4).
// Latency : expectations are tagged with the edge after which they must hold.
// Backpres: n/a; a monitor compares every cycle against the scoreboard queue.
module tb_alarm_cnt_bank;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  incr_en_i, decr_en_i, alarm_clr_i;
  logic [31:0] step_i;
  logic [7:0]  thresh_i;
  logic [31:0] cnt_o;
  logic [3:0]  alarm_o;
  logic        alarm_any_o;

  alarm_cnt_bank #(
    .NumCh(4), .Width(8), .ResetValue(8'h05), .LeakPeriod(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .incr_en_i(incr_en_i), .decr_en_i(decr_en_i),
    .step_i(step_i), .thresh_i(thresh_i), .alarm_clr_i(alarm_clr_i),
    .cnt_o(cnt_o), .alarm_o(alarm_o), .alarm_any_o(alarm_any_o)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // kind 0: cnt lane, 1: alarm_o vector, 2: alarm_any_o
  typedef struct {
    int       cyc;
    int       kind;
    int       lane;
    int       val;
    string    name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic exp_cnt(input int lane, input int v, input string nm);
    exp_t e;
    e.cyc = edge_cnt + 1; e.kind = 0; e.lane = lane; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic exp_alm(input int v, input string nm);
    exp_t e;
    e.cyc = edge_cnt + 1; e.kind = 1; e.lane = 0; e.val = v; e.name = nm;
    exp_q.push_back(e);
    e.kind = 2; e.val = (v != 0) ? 1 : 0; e.name = {nm, "_any"};
    exp_q.push_back(e);
  endtask

  task automatic set_step(input int lane, input int v);
    step_i[lane*8 +: 8] = v[7:0];
  endtask

  // Monitor: after each edge, compare every expectation due now; flag overdue ones.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= edge_cnt) begin
          int got;
          case (exp_q[i].kind)
            0:       got = int'(cnt_o[exp_q[i].lane*8 +: 8]);
            1:       got = int'(alarm_o);
            default: got = int'(alarm_any_o);
          endcase
          checks++;
          if (exp_q[i].cyc < edge_cnt) begin
            fails++;
            $display("FAIL %s lane%0d: overdue (due edge %0d, now %0d)",
                     exp_q[i].name, exp_q[i].lane, exp_q[i].cyc, edge_cnt);
          end else if (got != exp_q[i].val) begin
            fails++;
            $display("FAIL %s lane%0d: got %0d expected %0d",
                     exp_q[i].name, exp_q[i].lane, got, exp_q[i].val);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; incr_en_i = '0; decr_en_i = '0; alarm_clr_i = '0;
    step_i = '0; thresh_i = '0;
    tick; tick;
    for (int k = 0; k < 4; k++) exp_cnt(k, 5, "rst_cnt");
    exp_alm(0, "rst_alarm");
    tick;

`ifdef ALARM_CNT_BANK_LEAK_EN
    // Prescaler is 0 before e1, pulse before e4, e8, e12, e16.
    rst_i = 1'b0;
    incr_en_i = 4'b1000; decr_en_i = 4'b1011;
    set_step(0, 2); set_step(1, 2); set_step(3, 1);
    exp_cnt(0, 3, "leak_load0"); exp_cnt(1, 3, "leak_load1");
    tick;                                            // e1
    incr_en_i = 4'b1010; decr_en_i = 4'b1000; set_step(1, 1);
    exp_cnt(0, 3, "leak_e2_ch0"); exp_cnt(1, 4, "leak_e2_ch1");
    tick;                                            // e2
    tick;                                            // e3
    exp_cnt(0, 2, "leak_e4_ch0"); exp_cnt(1, 6, "leak_e4_ch1");
    exp_cnt(2, 4, "leak_e4_ch2"); exp_cnt(3, 5, "leak_both_skip");
    tick;                                            // e4
    exp_cnt(0, 2, "leak_e5_ch0");
    tick; tick; tick;                                // e5..e7
    exp_cnt(0, 1, "leak_e8_ch0"); exp_cnt(1, 10, "leak_e8_ch1");
    tick;                                            // e8
    tick; tick; tick;
    exp_cnt(0, 0, "leak_e12_ch0");
    tick;                                            // e12
    tick; tick; tick;
    exp_cnt(0, 0, "leak_e16_floor"); exp_cnt(1, 18, "leak_e16_ch1");
    exp_cnt(2, 1, "leak_e16_ch2"); exp_cnt(3, 5, "leak_e16_ch3");
    tick;                                            // e16
`else
    // Reset asserted mid-increment.
    rst_i = 1'b0; incr_en_i = 4'hf; step_i = 32'h0101_0101;
    for (int k = 0; k < 4; k++) exp_cnt(k, 6, "incr_pre_rst");
    tick;
    rst_i = 1'b1;
    for (int k = 0; k < 4; k++) exp_cnt(k, 5, "rst_mid_incr");
    tick;
    rst_i = 1'b0;

    // Load 250, 3, 20, 0.
    incr_en_i = 4'b0101; decr_en_i = 4'b1010;
    set_step(0, 245); set_step(1, 2); set_step(2, 15); set_step(3, 5);
    exp_cnt(0, 250, "load0"); exp_cnt(1, 3, "load1");
    exp_cnt(2, 20, "load2"); exp_cnt(3, 0, "load3");
    tick;
    // Saturate up, saturate down, both-asserted hold.
    incr_en_i = 4'b0101; decr_en_i = 4'b0110;
    set_step(0, 10); set_step(1, 7); set_step(2, 4); set_step(3, 0);
    exp_cnt(0, 255, "sat_hi"); exp_cnt(1, 0, "sat_lo");
    exp_cnt(2, 20, "both_hold"); exp_cnt(3, 0, "idle_ch3");
    tick;
    incr_en_i = 4'b0101; decr_en_i = 4'b0010; set_step(2, 0);
    exp_cnt(0, 255, "sat_hi_hold"); exp_cnt(1, 0, "sat_lo_hold");
    exp_cnt(2, 20, "step0_hold");
    tick;
    incr_en_i = '0; decr_en_i = 4'b0101; set_step(0, 255); set_step(2, 20);
    exp_cnt(0, 0, "dec_to0_ch0"); exp_cnt(2, 0, "dec_to0_ch2");
    tick;

    // Threshold 16, ch3 counts up by 8.
    decr_en_i = '0; thresh_i = 8'd16; incr_en_i = 4'b1000; set_step(3, 8);
    exp_cnt(3, 8, "thr_e1"); exp_alm(0, "thr_e1_alarm");
    tick;
    exp_cnt(3, 16, "thr_e2"); exp_alm(0, "thr_e2_alarm");
    tick;
    incr_en_i = '0;
    exp_cnt(3, 16, "thr_e3"); exp_alm(8, "alarm_set"); exp_cnt(0, 0, "indep_ch0");
    tick;
    alarm_clr_i = 4'b1000;
    exp_alm(8, "clr_blocked");
    tick;
    alarm_clr_i = '0; decr_en_i = 4'b1000;
    exp_cnt(3, 8, "dec_to8"); exp_alm(8, "sticky_after_dec");
    tick;
    decr_en_i = '0; alarm_clr_i = 4'b1000;
    exp_alm(0, "clr_ok");
    tick;

    // Threshold 0 disables, raising it sets one cycle later, lowering keeps it.
    alarm_clr_i = '0; thresh_i = 8'd0; incr_en_i = 4'b1000; set_step(3, 255);
    exp_cnt(3, 255, "sat_ch3"); exp_alm(0, "thr0_e1");
    tick;
    incr_en_i = '0;
    exp_alm(0, "thr0_no_alarm");
    tick;
    thresh_i = 8'd200;
    exp_alm(8, "thr_raise");
    tick;
    thresh_i = 8'd0;
    exp_alm(8, "thr_change_keeps");
    tick;
    alarm_clr_i = 4'b1000;
    exp_alm(0, "clr_thr0");
    tick;

    // No leak in this build: an idle channel holds.
    alarm_clr_i = '0; incr_en_i = 4'b0001; set_step(0, 3);
    exp_cnt(0, 3, "ch0_to3");
    tick;
    incr_en_i = '0;
    repeat (9) tick;
    exp_cnt(0, 3, "no_leak");
    tick;
`endif

    incr_en_i = '0; decr_en_i = '0; alarm_clr_i = '0;
    tick; tick;
    while (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL %s: never checked (due edge %0d)", exp_q[0].name, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
